// File: rtl/user_mux_pkg.sv
// Shared constants for the user-project pad multiplexer: pad count, FSM states
// and the value every pad field takes while no project is connected.
package user_mux_pkg;

  localparam int PAD_W      = 43;
  localparam int NUM_FIELDS = 7;

  typedef enum logic [1:0] {
    ACTIVE     = 2'd0,
    DRAIN      = 2'd1,
    RESET_HOLD = 2'd2
  } state_e;

  localparam logic SAFE_OUT = 1'b0;
  localparam logic SAFE_OE  = 1'b0;
  localparam logic SAFE_CS  = 1'b0;
  localparam logic SAFE_SL  = 1'b0;
  localparam logic SAFE_PU  = 1'b0;
  localparam logic SAFE_PD  = 1'b0;
  localparam logic SAFE_IE  = 1'b1;

  // Field order used throughout: out, oe, cs, sl, pu, pd, ie (bit 0 = out).
  localparam logic [NUM_FIELDS-1:0] SAFE_BITS =
    {SAFE_IE, SAFE_PD, SAFE_PU, SAFE_SL, SAFE_CS, SAFE_OE, SAFE_OUT};

endpackage

// File: rtl/user_project_mux_ctrl_pad_bundle_mux.sv
// Picks one project's PAD_W slice of a flattened bundle field, or drives the
// field's safe constant while the controller is not connected.
module pad_bundle_mux #(
  parameter int   NUM_PROJ = 4,
  parameter int   PAD_W    = 43,
  parameter int   ID_W     = 2,
  parameter logic SAFE_BIT = 1'b0
) (
  input  logic [NUM_PROJ*PAD_W-1:0] bundles_i,
  input  logic [ID_W-1:0]           sel_i,
  input  logic                      force_safe_i,
  output logic [PAD_W-1:0]          pad_o
);

  logic [PAD_W-1:0] sel_s;

  // AND-OR select keeps the path free of priority logic
  always_comb begin
    sel_s = {PAD_W{1'b0}};
    for (int p = 0; p < NUM_PROJ; p++) begin
      sel_s = sel_s | (bundles_i[p*PAD_W +: PAD_W] & {PAD_W{sel_i == ID_W'(p)}});
    end
    if (force_safe_i) begin
      pad_o = {PAD_W{SAFE_BIT}};
    end else begin
      pad_o = sel_s;
    end
  end

endmodule

// File: rtl/user_project_mux_ctrl.sv
// Shares the user GPIO pads between NUM_PROJ projects with a drain/reset/connect
// switch sequence. Define PAD_OUT_REG_EN to register the pad_io_* outputs.
module user_project_mux_ctrl
  import user_mux_pkg::*;
#(
  parameter int NUM_PROJ     = 4,
  parameter int PAD_W        = user_mux_pkg::PAD_W,
  parameter int GUARD_CYCLES = 4,
  parameter int RST_CYCLES   = 8,
  parameter int DEFAULT_ID   = 0,
  parameter int ID_W         = (NUM_PROJ > 2) ? $clog2(NUM_PROJ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic                      sel_valid,
  input  logic [ID_W-1:0]           sel_id,
  output logic                      sel_ready,
  output logic                      sel_err,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id,
  output logic [NUM_PROJ-1:0]       proj_rst_n,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_out,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_oe,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_cs,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_sl,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_pu,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_pd,
  input  logic [NUM_PROJ*PAD_W-1:0] proj_io_ie,
  output logic [PAD_W-1:0]          proj_io_in,
  input  logic [PAD_W-1:0]          pad_io_in,
  output logic [PAD_W-1:0]          pad_io_out,
  output logic [PAD_W-1:0]          pad_io_oe,
  output logic [PAD_W-1:0]          pad_io_cs,
  output logic [PAD_W-1:0]          pad_io_sl,
  output logic [PAD_W-1:0]          pad_io_pu,
  output logic [PAD_W-1:0]          pad_io_pd,
  output logic [PAD_W-1:0]          pad_io_ie
);

  localparam int MAX_CYC = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [ID_W:0] NUM_PROJ_C = (ID_W+1)'(NUM_PROJ);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic              sel_err_q, sel_err_d;
  logic              id_ok_s;

  assign id_ok_s = ({1'b0, sel_id} < NUM_PROJ_C);

  // Switch sequencer: ACTIVE -> DRAIN -> RESET_HOLD -> ACTIVE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_id_d = active_id_q;
    req_id_d    = req_id_q;
    sel_err_d   = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (sel_valid) begin
          if (id_ok_s) begin
            state_d  = DRAIN;
            cnt_d    = {CNT_W{1'b0}};
            req_id_d = sel_id;
          end else begin
            sel_err_d = 1'b1;
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          state_d     = RESET_HOLD;
          cnt_d       = {CNT_W{1'b0}};
          active_id_d = req_id_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESET_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ACTIVE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_HOLD;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state; reset discards any latched request
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= {CNT_W{1'b0}};
      active_id_q <= ID_W'(DEFAULT_ID);
      req_id_q    <= ID_W'(DEFAULT_ID);
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_id_q <= active_id_d;
      req_id_q    <= req_id_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign sel_ready  = (state_q == ACTIVE);
  assign busy       = (state_q != ACTIVE);
  assign sel_err    = sel_err_q;
  assign active_id  = active_id_q;
  assign proj_io_in = pad_io_in;

  // Only the connected project is out of reset
  always_comb begin
    proj_rst_n = {NUM_PROJ{1'b0}};
    for (int p = 0; p < NUM_PROJ; p++) begin
      proj_rst_n[p] = (state_q == ACTIVE) && (active_id_q == ID_W'(p));
    end
  end

  logic [NUM_FIELDS-1:0][NUM_PROJ*PAD_W-1:0] bund_s;
  logic [NUM_FIELDS-1:0][PAD_W-1:0]          pad_d;
  logic [NUM_FIELDS-1:0][PAD_W-1:0]          pad_s;

  assign bund_s = {proj_io_ie, proj_io_pd, proj_io_pu, proj_io_sl,
                   proj_io_cs, proj_io_oe, proj_io_out};

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    pad_bundle_mux #(
      .NUM_PROJ (NUM_PROJ),
      .PAD_W    (PAD_W),
      .ID_W     (ID_W),
      .SAFE_BIT (SAFE_BITS[g])
    ) u_mux (
      .bundles_i    (bund_s[g]),
      .sel_i        (active_id_q),
      .force_safe_i (state_q != ACTIVE),
      .pad_o        (pad_d[g])
    );
  end

`ifdef PAD_OUT_REG_EN
  logic [NUM_FIELDS-1:0][PAD_W-1:0] pad_q;

  // Pad retiming stage, reset to the safe pad value
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        pad_q[f] <= {PAD_W{SAFE_BITS[f]}};
      end
    end else begin
      pad_q <= pad_d;
    end
  end

  assign pad_s = pad_q;
`else
  assign pad_s = pad_d;
`endif

  assign pad_io_out = pad_s[0];
  assign pad_io_oe  = pad_s[1];
  assign pad_io_cs  = pad_s[2];
  assign pad_io_sl  = pad_s[3];
  assign pad_io_pu  = pad_s[4];
  assign pad_io_pd  = pad_s[5];
  assign pad_io_ie  = pad_s[6];

endmodule

// File: tb/tb_user_project_mux_ctrl.sv
// Directed bench for user_project_mux_ctrl: switch table plus hand sequences
// for stalled requests, bad ids (3-project instance) and reset mid-switch.
module tb_user_project_mux_ctrl;

  localparam int NP = 4;
  localparam int PW = 43;
`ifdef PAD_OUT_REG_EN
  localparam bit PD = 1'b1;
`else
  localparam bit PD = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          sel_valid, sel_ready, sel_err, busy;
  logic [1:0]    sel_id, active_id;
  logic [NP-1:0] proj_rst_n;
  logic [NP*PW-1:0] p_out, p_oe, p_cs, p_sl, p_pu, p_pd, p_ie;
  logic [PW-1:0] proj_io_in, pad_io_in;
  logic [PW-1:0] pad_out, pad_oe, pad_cs, pad_sl, pad_pu, pad_pd, pad_ie;

  logic          v3, ready3, err3, busy3;
  logic [1:0]    id3, aid3;
  logic [2:0]    rst3;
  logic [PW-1:0] in3, out3, oe3, cs3, sl3, pu3, pd3, ie3;

  user_project_mux_ctrl #(.NUM_PROJ(4), .PAD_W(PW), .GUARD_CYCLES(4),
                          .RST_CYCLES(8), .DEFAULT_ID(0)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sel_valid(sel_valid), .sel_id(sel_id),
    .sel_ready(sel_ready), .sel_err(sel_err), .busy(busy), .active_id(active_id),
    .proj_rst_n(proj_rst_n), .proj_io_out(p_out), .proj_io_oe(p_oe),
    .proj_io_cs(p_cs), .proj_io_sl(p_sl), .proj_io_pu(p_pu), .proj_io_pd(p_pd),
    .proj_io_ie(p_ie), .proj_io_in(proj_io_in), .pad_io_in(pad_io_in),
    .pad_io_out(pad_out), .pad_io_oe(pad_oe), .pad_io_cs(pad_cs),
    .pad_io_sl(pad_sl), .pad_io_pu(pad_pu), .pad_io_pd(pad_pd), .pad_io_ie(pad_ie)
  );

  user_project_mux_ctrl #(.NUM_PROJ(3), .PAD_W(PW), .GUARD_CYCLES(4),
                          .RST_CYCLES(8), .DEFAULT_ID(0)) dut3 (
    .clk_i(clk_i), .rst_n(rst_n), .sel_valid(v3), .sel_id(id3),
    .sel_ready(ready3), .sel_err(err3), .busy(busy3), .active_id(aid3),
    .proj_rst_n(rst3), .proj_io_out(p_out[3*PW-1:0]), .proj_io_oe(p_oe[3*PW-1:0]),
    .proj_io_cs(p_cs[3*PW-1:0]), .proj_io_sl(p_sl[3*PW-1:0]),
    .proj_io_pu(p_pu[3*PW-1:0]), .proj_io_pd(p_pd[3*PW-1:0]),
    .proj_io_ie(p_ie[3*PW-1:0]), .proj_io_in(in3), .pad_io_in(pad_io_in),
    .pad_io_out(out3), .pad_io_oe(oe3), .pad_io_cs(cs3), .pad_io_sl(sl3),
    .pad_io_pu(pu3), .pad_io_pd(pd3), .pad_io_ie(ie3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [PW-1:0] pat(input int f, input int p);
    logic [34:0] lo;
    lo = 35'h1A5A5A5A5 ^ 35'(p * 97 + f * 13);
    return {4'(f), 4'(p), lo};
  endfunction

  function automatic logic [PW-1:0] exp_pad(input int f, input bit conn, input int id);
    if (conn) return pat(f, id);
    return (f == 6) ? {PW{1'b1}} : {PW{1'b0}};
  endfunction

  function automatic logic [PW-1:0] got_pad(input int f);
    case (f)
      0: return pad_out;
      1: return pad_oe;
      2: return pad_cs;
      3: return pad_sl;
      4: return pad_pu;
      5: return pad_pd;
      default: return pad_ie;
    endcase
  endfunction

  task automatic chk(input string nm, input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s [%s] got %h want %h", nm, tag, got, want);
    end
  endtask

  bit prev_conn = 1'b0;
  int prev_id   = 0;

  // Check one cycle of the main DUT, then advance to just after the next edge.
  task automatic cyc(input bit conn, input int id, input int aid, input string tag);
    bit pc;
    int pi;
    pc = PD ? prev_conn : conn;
    pi = PD ? prev_id : id;
    chk("sel_ready", tag, 64'(sel_ready), 64'(conn));
    chk("busy", tag, 64'(busy), 64'(!conn));
    chk("active_id", tag, 64'(active_id), 64'(aid));
    chk("proj_rst_n", tag, 64'(proj_rst_n), conn ? (64'd1 << id) : 64'd0);
    chk("sel_err", tag, 64'(sel_err), 64'd0);
    chk("proj_io_in", tag, 64'(proj_io_in), 64'(pad_io_in));
    for (int f = 0; f < 7; f++) begin
      chk($sformatf("pad_f%0d", f), tag, 64'(got_pad(f)), 64'(exp_pad(f, pc, pi)));
    end
    prev_conn = conn;
    prev_id   = id;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_switch(input int nid, input int oid, input bit hold,
                            input int hold_id, input string tag);
    sel_valid = 1'b1;
    sel_id    = 2'(nid);
    cyc(1'b1, oid, oid, {tag, ":acc"});
    sel_valid = hold;
    sel_id    = 2'(hold_id);
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b0, nid, (c >= 5) ? nid : oid, $sformatf("%s:c%0d", tag, c));
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] exp_rst;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int oid;
    tbl[0] = '{2, 4'b0100};
    tbl[1] = '{1, 4'b0010};
    tbl[2] = '{3, 4'b1000};
    tbl[3] = '{0, 4'b0001};
    tbl[4] = '{1, 4'b0010};
    tbl[5] = '{1, 4'b0010};
    tbl[6] = '{0, 4'b0001};

    for (int p = 0; p < NP; p++) begin
      p_out[p*PW +: PW] = pat(0, p);
      p_oe [p*PW +: PW] = pat(1, p);
      p_cs [p*PW +: PW] = pat(2, p);
      p_sl [p*PW +: PW] = pat(3, p);
      p_pu [p*PW +: PW] = pat(4, p);
      p_pd [p*PW +: PW] = pat(5, p);
      p_ie [p*PW +: PW] = pat(6, p);
    end
    sel_valid = 1'b0;
    sel_id    = 2'd0;
    v3        = 1'b0;
    id3       = 2'd0;
    pad_io_in = 43'h2AA_5555_AAAA;

    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    cyc(1'b0, 0, 0, "rst0");
    cyc(1'b0, 0, 0, "rst1");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) cyc(1'b0, 0, 0, $sformatf("boot%0d", c));
    chk("boot_rst", "act0", 64'(proj_rst_n), 64'(4'b0001));
    pad_io_in = 43'h155_AAAA_5555;

    oid = 0;
    for (int i = 0; i < 7; i++) begin
      run_switch(tbl[i].id, oid, 1'b0, 0, $sformatf("tbl%0d", i));
      chk("tbl_rst", $sformatf("tbl%0d", i), 64'(proj_rst_n), 64'(tbl[i].exp_rst));
      oid = tbl[i].id;
    end

    // Out-of-range id on the three-project instance
    v3  = 1'b1;
    id3 = 2'd3;
    chk("err_ready", "e0", 64'(ready3), 64'd1);
    cyc(1'b1, 0, 0, "err_pre");
    v3 = 1'b0;
    chk("err_pulse", "e1", 64'(err3), 64'd1);
    chk("err_aid", "e1", 64'(aid3), 64'd0);
    chk("err_rst", "e1", 64'(rst3), 64'(3'b001));
    chk("err_busy", "e1", 64'(busy3), 64'd0);
    chk("err_pad", "e1", 64'(out3), 64'(pat(0, 0)));
    cyc(1'b1, 0, 0, "err_post");
    chk("err_clear", "e2", 64'(err3), 64'd0);
    chk("err_rst2", "e2", 64'(rst3), 64'(3'b001));

    // Request held through a busy sequence is taken on the first ACTIVE cycle
    run_switch(2, 0, 1'b1, 3, "hold1");
    run_switch(3, 2, 1'b0, 0, "hold2");
    chk("hold_rst", "h", 64'(proj_rst_n), 64'(4'b1000));
    run_switch(0, 3, 1'b0, 0, "back0");

    // Reset during DRAIN cycle 2 of a 0->3 switch
    sel_valid = 1'b1;
    sel_id    = 2'd3;
    cyc(1'b1, 0, 0, "r:acc");
    sel_valid = 1'b0;
    cyc(1'b0, 3, 0, "r:d1");
    rst_n = 1'b0;
    cyc(1'b0, 3, 0, "r:d2");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) cyc(1'b0, 0, 0, $sformatf("r:rh%0d", c));
    chk("rmid_rst", "r", 64'(proj_rst_n), 64'(4'b0001));
    cyc(1'b1, 0, 0, "r:act");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
